burst_addr_gen: RTL
===================

# burst_addr_gen

Burst column-address generator for the SDRAM controller. It sits directly downstream of the carry-mask stage. On a read/write command it captures the start column, burst mode and the 8-bit carry mask. It then emits one column address per beat, wrapping inside the burst boundary defined by the mask, and flags the last beat to the command/data sequencer.

## Interface
- COL_WIDTH, 10, column address width (≥8)
- Clock  in  1  rising-edge clock
- ResetN  in  1  reset, synchronous, active-low
- Start  in  1  burst request; sampled when accepting (see Operation)
- StartCol  in  COL_WIDTH  first column of the burst
- AddrMode  in  1  0 = sequential, 1 = interleaved
- BurstLength  in  3  mode-register code: 0→1, 1→2, 2→4, 3→8, 7→full page; 4/5/6 reserved
- CarryMaskIn  in  8  mask from the carry-mask stage (bit i = 1: column bit i wraps in-burst)
- Stall  in  1  consumer not ready; hold current beat
- Stop  in  1  burst terminate
- ColAddr  out  COL_WIDTH  current beat column
- ColValid  out  1  ColAddr valid this cycle
- Last  out  1  current beat is final
- Busy  out  1  burst in progress (state BURST)

## Operation
- Effective mask M (COL_WIDTH bits):
  - Bits [7:0] = CarryMaskIn, captured at Start.
  - Bits above 7 replicate CarryMaskIn[7].
  - M forced to 0 for reserved codes 4/5/6, and for code 7 with AddrMode = 1.
- Beat counter B (COL_WIDTH bits) is 0 at beat 0.
- Burst length = M + 1 beats. Last = ColValid & (B == M).
- Sequential: next ColAddr = (ColAddr & ~M) | ((ColAddr + 1) & M). Carry out of the masked field is discarded.
- Interleaved: ColAddr = StartCol_q ^ (B & M).
- FSM states:
  - IDLE → BURST on Start.
  - BURST → IDLE on (Last & ~Stall) with no Start, or on Stop.
  - BURST → BURST (reload) on Last & ~Stall & Start, giving back-to-back bursts.
- Start is accepted in IDLE, or in BURST only on a Last & ~Stall cycle. Start at any other time is ignored.
- Stop in BURST: the beat shown this cycle is the final one issued, and the FSM goes to IDLE next cycle.
- Precedence when events coincide: Stop > Start > Stall. Stop is ignored in IDLE.

## Timing
- Reset (ResetN = 0 at an edge): state IDLE, ColAddr = 0, ColValid = 0, Last = 0, Busy = 0, B = 0. Reset aborts a burst mid-operation with no further beats.
- Latency: Start sampled at edge N → ColValid = 1 and ColAddr = StartCol from edge N+1.
- One beat advances per cycle with Stall = 0.
- Stall = 1: ColAddr, ColValid, Last and B hold.
- After the final beat is accepted: ColValid = 0 and Busy = 0 on the next cycle, unless a back-to-back Start reloads.
- Full page (M all ones): 2^COL_WIDTH beats. The column wraps 2^COL_WIDTH−1 → 0.
- 1-beat burst: Last = 1 on the first and only beat.

## Configuration
- BURST_ADDR_GEN_INTERLEAVE_EN defined: AddrMode = 1 selects the interleaved XOR sequence, and code 7 with AddrMode = 1 is reserved (single beat).
- Not defined: AddrMode is ignored and every burst is sequential, including full page with AddrMode = 1. The XOR datapath is not built.

## Test plan
- Sequential, code 2, mask 8'b00000011, StartCol 0x0A6 → ColAddr 0x0A6, 0x0A7, 0x0A4, 0x0A5. Last on the 4th beat; Busy = 0 the following cycle.
- Interleaved (macro on), code 3, mask 8'b00000111, StartCol 0x0A5 → 0x0A5, 0x0A4, 0x0A7, 0x0A6, 0x0A1, 0x0A0, 0x0A3, 0x0A2.
- Full page, sequential, mask 8'hFF, StartCol 0x3FE → 0x3FE, 0x3FF, 0x000, … 1024 beats total, Last at 0x3FD.
- Code 2 from 0x010 with Stall = 1 for 2 cycles on beat 1 → 0x011 held 3 cycles with ColValid = 1. Then 0x012, 0x013 (Last).
- Code 3 from 0x020:
  - Stop on beat 2 (0x022) → no further beats; IDLE next cycle.
  - Then a Start on a Last cycle of a new code-1 burst → next burst's beat 0 appears the next cycle with no gap.
- ResetN = 0 mid-burst → all outputs 0 next cycle.
- Code 5 (reserved) → exactly one beat with Last = 1.

Source files
------------

// File: rtl/burst_addr_gen.sv
// -----------------------------------------------------------------------------
// burst_addr_gen
//   Burst column-address generator for the SDRAM controller. A read/write
//   command captures the start column, the burst mode and the 8-bit carry mask
//   from the carry-mask stage. The block then emits one column address per
//   beat, wrapping inside the burst boundary that the mask defines. It flags
//   the final beat to the command/data sequencer.
//
//   Optional feature macro: BURST_ADDR_GEN_INTERLEAVE_EN
//     defined     : AddrMode = 1 selects the interleaved (XOR) sequence.
//                   Code 7 with AddrMode = 1 is reserved and gives one beat.
//     not defined : AddrMode is ignored and every burst is sequential.
//
// Ports
//   Clock        in   rising-edge clock
//   ResetN       in   synchronous active-low reset
//   Start        in   burst request (accepted in IDLE, or on an accepted Last beat)
//   StartCol     in   first column of the burst
//   AddrMode     in   0 = sequential, 1 = interleaved
//   BurstLength  in   mode-register burst code (0..3, 7 = full page, 4..6 reserved)
//   CarryMaskIn  in   carry mask (bit i = 1: column bit i wraps in-burst)
//   Stall        in   consumer not ready; hold the current beat
//   Stop         in   burst terminate; the beat shown this cycle is the last one
//   ColAddr      out  current beat column
//   ColValid     out  ColAddr valid this cycle
//   Last         out  current beat is the final one
//   Busy         out  burst in progress
// -----------------------------------------------------------------------------
module burst_addr_gen #(
    parameter int COL_WIDTH = 10
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 Start,
    input  logic [COL_WIDTH-1:0] StartCol,
    input  logic                 AddrMode,
    input  logic [2:0]           BurstLength,
    input  logic [7:0]           CarryMaskIn,
    input  logic                 Stall,
    input  logic                 Stop,
    output logic [COL_WIDTH-1:0] ColAddr,
    output logic                 ColValid,
    output logic                 Last,
    output logic                 Busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam logic [COL_WIDTH-1:0] ONE = COL_WIDTH'(1);

    logic [0:0]           state;
    logic [COL_WIDTH-1:0] beat;       // beat counter, 0 on the first beat
    logic [COL_WIDTH-1:0] mask_q;     // effective wrap mask of the running burst
    logic [COL_WIDTH-1:0] mask_eff;   // effective mask built from the inputs
    logic [COL_WIDTH-1:0] next_addr;
    logic                 load;
    logic                 finish;

`ifdef BURST_ADDR_GEN_INTERLEAVE_EN
    logic                 mode_q;
    logic [COL_WIDTH-1:0] start_col_q;
`else
    logic                 unused_mode;
    assign unused_mode = AddrMode;
`endif

    // Mask bits above 7 replicate bit 7. This lets an all-ones carry mask
    // cover the whole page. Reserved codes collapse to a single-beat burst.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        mask_eff = '0;
        for (int i = 0; i < COL_WIDTH; i++) begin
            mask_eff[i] = (i < 8) ? CarryMaskIn[i % 8] : CarryMaskIn[7];
        end
        if (BurstLength inside {3'd4, 3'd5, 3'd6}) begin
            mask_eff = '0;
        end
`ifdef BURST_ADDR_GEN_INTERLEAVE_EN
        if (BurstLength == 3'd7 && AddrMode) begin
            mask_eff = '0;
        end
`endif
    end

    // The sequential increment only ripples through the masked field. Bits
    // outside the mask keep their value, and any carry out of the field is lost.
    always_comb begin
        next_addr = (ColAddr & ~mask_q) | ((ColAddr + ONE) & mask_q);
`ifdef BURST_ADDR_GEN_INTERLEAVE_EN
        if (mode_q) begin
            next_addr = start_col_q ^ ((beat + ONE) & mask_q);
        end
`endif
    end

    assign Busy   = (state == BURST);
    assign Last   = ColValid && (beat == mask_q);
    // A burst ends on Stop, or when its final beat is accepted. Stop takes
    // precedence over Start, and Start takes precedence over Stall.
    assign finish = Busy && (Stop || (Last && !Stall));
    assign load   = Start && (!Busy || (finish && !Stop));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values and no ordering race arises.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state       <= IDLE;
            ColAddr     <= '0;
            ColValid    <= 1'b0;
            beat        <= '0;
            mask_q      <= '0;
`ifdef BURST_ADDR_GEN_INTERLEAVE_EN
            mode_q      <= 1'b0;
            start_col_q <= '0;
`endif
        end else if (load) begin
            state       <= BURST;
            ColAddr     <= StartCol;
            ColValid    <= 1'b1;
            beat        <= '0;
            mask_q      <= mask_eff;
`ifdef BURST_ADDR_GEN_INTERLEAVE_EN
            mode_q      <= AddrMode;
            start_col_q <= StartCol;
`endif
        end else if (finish) begin
            state       <= IDLE;
            ColValid    <= 1'b0;
            beat        <= '0;
        end else if (Busy && !Stall) begin
            beat        <= beat + ONE;
            ColAddr     <= next_addr;
        end
    end

endmodule
